// File: rtl/tarb_pkg.sv
// Shared ray-tracer types used by the tree-cache arbiter (tarb).
package tarb_pkg;

    localparam int MAX_RAYS_DEF   = 64;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic [7:0]  ray_id;
        logic [23:0] node_addr;
    } tarb_t;

    typedef enum logic {
        SRC_TRAV = 1'b0,
        SRC_SS   = 1'b1
    } rr_src_e;

endpackage

// File: rtl/ff_ar.sv
// Plain register with asynchronous active-high reset.
module ff_ar #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/ff_ar_en.sv
// Load-enabled register with asynchronous active-high reset.
module ff_ar_en #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO; rd_data shows the head entry whenever not empty.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          wr_ok, rd_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tarb_rr_pick.sv
// Grant select: trav/ss round-robin, newray only when both are empty.
module tarb_rr_pick
    import tarb_pkg::*;
(
    input  logic    trav_empty,
    input  logic    ss_empty,
    input  logic    nr_empty,
    input  rr_src_e last_grant,
    output logic    gnt_trav,
    output logic    gnt_ss,
    output logic    gnt_nr
);

    logic t, s, n;

    assign t = !trav_empty;
    assign s = !ss_empty;
    assign n = !nr_empty;

    always_comb begin
        gnt_trav = 1'b0;
        gnt_ss   = 1'b0;
        gnt_nr   = 1'b0;
        unique case (1'b1)
            (t && s): begin
                gnt_trav = last_grant == SRC_SS;
                gnt_ss   = last_grant == SRC_TRAV;
            end
            (t && !s):       gnt_trav = 1'b1;
            (!t && s):       gnt_ss   = 1'b1;
            (!t && !s && n): gnt_nr   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/tarb.sv
// Tree-cache arbiter: three buffered requesters merged into one
// registered stream, with a cap on rays in flight.
module tarb
    import tarb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MAX_RAYS   = MAX_RAYS_DEF,
    localparam int CW        = $clog2(MAX_RAYS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trav_to_tarb_valid,
    input  tarb_t         trav_to_tarb_data,
    output logic          trav_to_tarb_stall,
    input  logic          ss_to_tarb_valid,
    input  tarb_t         ss_to_tarb_data,
    output logic          ss_to_tarb_stall,
    input  logic          newray_to_tarb_valid,
    input  tarb_t         newray_to_tarb_data,
    output logic          newray_to_tarb_stall,
    output logic          tarb_to_tcache_valid,
    output tarb_t         tarb_to_tcache_data,
    input  logic          tarb_to_tcache_stall,
    input  logic          ray_retire,
    output logic [CW-1:0] rays_in_flight
);

    localparam int W = $bits(tarb_t);

    logic    trav_full, trav_empty;
    logic    ss_full, ss_empty;
    logic    nr_full, nr_empty;
    tarb_t   trav_q, ss_q, nr_q, out_d;
    logic    gnt_trav, gnt_ss, gnt_nr, any_gnt;
    logic    out_free, at_cap, nr_push, ray_dec;
    logic    last_q;

    assign out_free = !(tarb_to_tcache_valid && tarb_to_tcache_stall);
    assign at_cap   = rays_in_flight == CW'(MAX_RAYS);
    assign any_gnt  = gnt_trav || gnt_ss || gnt_nr;

    assign trav_to_tarb_stall   = trav_full;
    assign ss_to_tarb_stall     = ss_full;
    assign newray_to_tarb_stall = nr_full || at_cap;
    assign nr_push = newray_to_tarb_valid && !newray_to_tarb_stall;

    fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_trav_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (trav_to_tarb_valid),
        .wr_data (trav_to_tarb_data),
        .rd_en   (gnt_trav && out_free),
        .rd_data (trav_q),
        .full    (trav_full),
        .empty   (trav_empty)
    );

    fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_ss_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ss_to_tarb_valid),
        .wr_data (ss_to_tarb_data),
        .rd_en   (gnt_ss && out_free),
        .rd_data (ss_q),
        .full    (ss_full),
        .empty   (ss_empty)
    );

    fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_nr_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (nr_push),
        .wr_data (newray_to_tarb_data),
        .rd_en   (gnt_nr && out_free),
        .rd_data (nr_q),
        .full    (nr_full),
        .empty   (nr_empty)
    );

    tarb_rr_pick u_pick (
        .trav_empty (trav_empty),
        .ss_empty   (ss_empty),
        .nr_empty   (nr_empty),
        .last_grant (rr_src_e'(last_q)),
        .gnt_trav   (gnt_trav),
        .gnt_ss     (gnt_ss),
        .gnt_nr     (gnt_nr)
    );

    always_comb begin
        out_d = '0;
        unique case (1'b1)
            gnt_trav: out_d = trav_q;
            gnt_ss:   out_d = ss_q;
            gnt_nr:   out_d = nr_q;
            default: ;
        endcase
    end

    // A held (stalled) output keeps valid high; otherwise valid follows grant.
    ff_ar #(.W(1)) u_out_vld (
        .clk (clk),
        .rst (rst),
        .d   (!out_free || any_gnt),
        .q   (tarb_to_tcache_valid)
    );

    ff_ar_en #(.W(W)) u_out_data (
        .clk (clk),
        .rst (rst),
        .en  (out_free && any_gnt),
        .d   (out_d),
        .q   (tarb_to_tcache_data)
    );

    ff_ar_en #(.W(1), .RST_VAL(1'b1)) u_last (
        .clk (clk),
        .rst (rst),
        .en  (out_free && (gnt_trav || gnt_ss)),
        .d   (gnt_ss),
        .q   (last_q)
    );

    assign ray_dec = ray_retire && (rays_in_flight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rays_in_flight <= '0;
        end else begin
            case ({nr_push, ray_dec})
                2'b10:   rays_in_flight <= rays_in_flight + CW'(1);
                2'b01:   rays_in_flight <= rays_in_flight - CW'(1);
                default: rays_in_flight <= rays_in_flight;
            endcase
        end
    end

    a_retire_underflow: assert property (@(posedge clk) disable iff (rst)
        !(ray_retire && rays_in_flight == '0));

    a_cap: assert property (@(posedge clk) disable iff (rst)
        rays_in_flight <= CW'(MAX_RAYS));

endmodule
